branch_recovery_ctrl: RTL and testbench

//  Consumer end of the branch-FU result interface (b_data). Accepts resolved BNE/JALR outcomes,

---
 rtl/core_pkg.sv | 26 ++
 rtl/rob_age_cmp.sv | 21 ++
 rtl/branch_recovery_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_branch_recovery_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the branch-recovery slice: ROB geometry, the branch
// result bundle and the recovery FSM state encoding.
package core_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int XLEN      = 32;

    // Resolved branch outcome as produced by fu_branch.
    typedef struct packed {
        logic             done;
        logic             mispredict;
        logic             hit;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  pc;
    } b_data_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WALK,
        ST_RESTORE,
        ST_REDIRECT
    } recov_state_e;

endpackage

// File: rtl/rob_age_cmp.sv
// Relative age of two ROB tags. Age is distance from the ROB head, so the
// comparison stays correct when the circular buffer has wrapped.
module rob_age_cmp #(
    parameter int TAG_W = core_pkg::TAG_W
) (
    input  logic [TAG_W-1:0] a,
    input  logic [TAG_W-1:0] b,
    input  logic [TAG_W-1:0] head,
    output logic             a_older
);
    import core_pkg::*;

    logic [TAG_W-1:0] age_a;
    logic [TAG_W-1:0] age_b;

    // Modular subtraction wraps naturally at TAG_W bits.
    assign age_a   = a - head;
    assign age_b   = b - head;
    assign a_older = (age_a < age_b);

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Branch recovery controller: frees checkpoints on correct predictions and,
// on a mispredict, sequences flush -> ROB walk (youngest to branch+1) ->
// rename checkpoint restore -> fetch redirect. All outputs are registered and
// pulse one cycle after the FSM state that produces them.
module branch_recovery_ctrl #(
    parameter int ROB_DEPTH = core_pkg::ROB_DEPTH,
    parameter int TAG_W     = core_pkg::TAG_W,
    parameter int XLEN      = core_pkg::XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             b_done,
    input  logic             b_mispredict,
    input  logic             b_hit,
    input  logic [TAG_W-1:0] b_tag,
    input  logic [XLEN-1:0]  b_pc,
    input  logic [TAG_W-1:0] rob_head,
    input  logic [TAG_W-1:0] rob_tail,
    output logic             flush_valid,
    output logic [TAG_W-1:0] flush_tag,
    output logic             walk_valid,
    output logic [TAG_W-1:0] walk_idx,
    output logic             ckpt_restore,
    output logic             ckpt_free,
    output logic [TAG_W-1:0] ckpt_tag,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             busy
);
    import core_pkg::*;

    localparam logic [TAG_W-1:0] ONE      = TAG_W'(1);
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(ROB_DEPTH - 1);

    recov_state_e     state_q, state_d;
    logic [TAG_W-1:0] cap_tag_q, cap_tag_d;
    logic [XLEN-1:0]  cap_pc_q, cap_pc_d;
    logic [TAG_W-1:0] walk_ptr_q, walk_ptr_d;
    logic             hold_valid_q, hold_valid_d;
    logic [TAG_W-1:0] hold_tag_q, hold_tag_d;

    logic             flush_valid_d, walk_valid_d, ckpt_restore_d, ckpt_free_d;
    logic             redirect_valid_d, busy_d;
    logic [TAG_W-1:0] flush_tag_d, walk_idx_d, ckpt_tag_d;
    logic [XLEN-1:0]  redirect_pc_d;

    logic             mp_req, hit_req;
    logic             mp_older, hit_older;
    logic             restart, free_req;
    logic [TAG_W-1:0] tail_m1;

    assign mp_req  = b_done & b_mispredict;
    // A result with both bits set is a mispredict; it never frees.
    assign hit_req = b_done & b_hit & ~b_mispredict;
    assign tail_m1 = rob_tail - ONE;

    // Recapture test: is the incoming mispredict older than the one in flight?
    rob_age_cmp #(.TAG_W(TAG_W)) u_mp_cmp (
        .a       (b_tag),
        .b       (cap_tag_q),
        .head    (rob_head),
        .a_older (mp_older)
    );

    // Hit filter: hits younger than the recovering branch are already squashed.
    rob_age_cmp #(.TAG_W(TAG_W)) u_hit_cmp (
        .a       (b_tag),
        .b       (cap_tag_q),
        .head    (rob_head),
        .a_older (hit_older)
    );

    // Next-state and next-output decode for the recovery FSM.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d          = state_q;
        cap_tag_d        = cap_tag_q;
        cap_pc_d         = cap_pc_q;
        walk_ptr_d       = walk_ptr_q;
        hold_valid_d     = hold_valid_q;
        hold_tag_d       = hold_tag_q;
        flush_valid_d    = 1'b0;
        flush_tag_d      = flush_tag;
        walk_valid_d     = 1'b0;
        walk_idx_d       = walk_idx;
        ckpt_restore_d   = 1'b0;
        ckpt_free_d      = 1'b0;
        ckpt_tag_d       = ckpt_tag;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        restart          = 1'b0;
        free_req         = 1'b0;

        if (state_q == ST_IDLE) begin
            if (mp_req) begin
                cap_tag_d = b_tag;
                cap_pc_d  = b_pc;
                state_d   = ST_FLUSH;
            end else if (hit_req) begin
                free_req = 1'b1;
            end
        end else begin
            if (mp_req && mp_older) begin
                // Older mispredict supersedes the current recovery entirely.
                cap_tag_d = b_tag;
                cap_pc_d  = b_pc;
                state_d   = ST_FLUSH;
                restart   = 1'b1;
            end else if (hit_req && hit_older) begin
                free_req = 1'b1;
            end

            if (!restart) begin
                case (state_q)
                    ST_FLUSH: begin
                        flush_valid_d = 1'b1;
                        flush_tag_d   = cap_tag_q;
                        walk_ptr_d    = tail_m1;
                        state_d       = (tail_m1 == cap_tag_q) ? ST_RESTORE : ST_WALK;
                    end
                    ST_WALK: begin
                        walk_valid_d = 1'b1;
                        walk_idx_d   = walk_ptr_q;
                        if (walk_ptr_q == cap_tag_q + ONE) begin
                            state_d = ST_RESTORE;
                        end else begin
                            walk_ptr_d = (walk_ptr_q == '0) ? LAST_IDX : walk_ptr_q - ONE;
                        end
                    end
                    ST_RESTORE: begin
                        ckpt_restore_d = 1'b1;
                        ckpt_tag_d     = cap_tag_q;
                        state_d        = ST_REDIRECT;
                    end
                    ST_REDIRECT: begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = cap_pc_q;
                        state_d          = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end

        // ckpt_tag is shared by restore and free; a free that lands on the
        // restore cycle parks in the hold register and goes out next cycle.
        if (ckpt_restore_d) begin
            if (free_req) begin
                hold_valid_d = 1'b1;
                hold_tag_d   = b_tag;
            end
        end else if (hold_valid_q) begin
            ckpt_free_d  = 1'b1;
            ckpt_tag_d   = hold_tag_q;
            hold_valid_d = free_req;
            hold_tag_d   = b_tag;
        end else if (free_req) begin
            ckpt_free_d = 1'b1;
            ckpt_tag_d  = b_tag;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, captured branch and registered outputs; reset abandons recovery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cap_tag_q      <= '0;
            cap_pc_q       <= '0;
            walk_ptr_q     <= '0;
            hold_valid_q   <= 1'b0;
            hold_tag_q     <= '0;
            flush_valid    <= 1'b0;
            flush_tag      <= '0;
            walk_valid     <= 1'b0;
            walk_idx       <= '0;
            ckpt_restore   <= 1'b0;
            ckpt_free      <= 1'b0;
            ckpt_tag       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            cap_tag_q      <= cap_tag_d;
            cap_pc_q       <= cap_pc_d;
            walk_ptr_q     <= walk_ptr_d;
            hold_valid_q   <= hold_valid_d;
            hold_tag_q     <= hold_tag_d;
            flush_valid    <= flush_valid_d;
            flush_tag      <= flush_tag_d;
            walk_valid     <= walk_valid_d;
            walk_idx       <= walk_idx_d;
            ckpt_restore   <= ckpt_restore_d;
            ckpt_free      <= ckpt_free_d;
            ckpt_tag       <= ckpt_tag_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            busy           <= busy_d;
        end
    end

    // A mispredict against an empty ROB has no valid branch entry to recover to.
    a_mispredict_nonempty: assert property (
        @(posedge clk) disable iff (reset)
        (b_done && b_mispredict) |-> (rob_tail != rob_head)
    );

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl. Inputs change just after a falling
// edge; registered outputs are compared on the following falling edge.
module tb_branch_recovery_ctrl;
    import core_pkg::*;

    typedef logic [52:0] obs_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             b_done, b_mispredict, b_hit;
    logic [TAG_W-1:0] b_tag;
    logic [XLEN-1:0]  b_pc;
    logic [TAG_W-1:0] rob_head, rob_tail;
    logic             flush_valid, walk_valid, ckpt_restore, ckpt_free;
    logic             redirect_valid, busy;
    logic [TAG_W-1:0] flush_tag, walk_idx, ckpt_tag;
    logic [XLEN-1:0]  redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    branch_recovery_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .b_done         (b_done),
        .b_mispredict   (b_mispredict),
        .b_hit          (b_hit),
        .b_tag          (b_tag),
        .b_pc           (b_pc),
        .rob_head       (rob_head),
        .rob_tail       (rob_tail),
        .flush_valid    (flush_valid),
        .flush_tag      (flush_tag),
        .walk_valid     (walk_valid),
        .walk_idx       (walk_idx),
        .ckpt_restore   (ckpt_restore),
        .ckpt_free      (ckpt_free),
        .ckpt_tag       (ckpt_tag),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Expected output snapshot; tag/pc fields are zero when their strobe is low.
    function automatic obs_t ev(bit f, int ft, bit w, int wi, bit rs, bit fr, int ct,
                                bit rd, logic [31:0] pc, bit bz);
        return {f, 5'(ft), w, 5'(wi), rs, fr, 5'(ct), rd, pc, bz};
    endfunction

    // Observed snapshot with the same masking of qualified fields.
    function automatic obs_t obs();
        logic [4:0]  ft = flush_valid ? flush_tag : 5'd0;
        logic [4:0]  wi = walk_valid ? walk_idx : 5'd0;
        logic [4:0]  ct = (ckpt_restore | ckpt_free) ? ckpt_tag : 5'd0;
        logic [31:0] pc = redirect_valid ? redirect_pc : 32'd0;
        return {flush_valid, ft, walk_valid, wi, ckpt_restore, ckpt_free, ct,
                redirect_valid, pc, busy};
    endfunction

    task automatic idle_in();
        b_done       = 1'b0;
        b_mispredict = 1'b0;
        b_hit        = 1'b0;
    endtask

    task automatic issue(input bit mp, input bit hit, input int tag, input logic [31:0] pc);
        b_done       = 1'b1;
        b_mispredict = mp;
        b_hit        = hit;
        b_tag        = 5'(tag);
        b_pc         = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_in();
        b_tag = '0; b_pc = '0; rob_head = '0; rob_tail = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({flush_valid, flush_tag, walk_valid, walk_idx, ckpt_restore, ckpt_free, ckpt_tag,
             redirect_valid, redirect_pc, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected all zero", obs());
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs() !== '0) begin
            n_errors++;
            $display("FAIL reset_release_idle: got %h expected 0", obs());
        end
    endtask

    task automatic test_hit();
        obs_t exp_q[$];
        exp_q.push_back(ev(0,0,0,0,0,1,3,0,0,0));
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rob_head = 5'd0; rob_tail = 5'd8;
        issue(0, 1, 3, 32'h0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            idle_in();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_errors++;
                $display("FAIL hit cycle %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_bne();
        obs_t exp_q[$];
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(1,4,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,7,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,6,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,5,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,0,0,1,0,4,0,0,1));
        exp_q.push_back(ev(0,0,0,0,0,0,0,1,32'h100,0));
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rob_head = 5'd0; rob_tail = 5'd8;
        issue(1, 0, 4, 32'h100);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            idle_in();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_errors++;
                $display("FAIL bne cycle %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t exp_q[$];
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(1,30,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,1,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,0,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,31,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,0,0,1,0,30,0,0,1));
        exp_q.push_back(ev(0,0,0,0,0,0,0,1,32'h2000,0));
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rob_head = 5'd28; rob_tail = 5'd2;
        issue(1, 0, 30, 32'h2000);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            idle_in();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_errors++;
                $display("FAIL wrap cycle %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    // Both mispredict and hit set: must recover, never free.
    task automatic test_empty_walk();
        obs_t exp_q[$];
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(1,9,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,0,0,1,0,9,0,0,1));
        exp_q.push_back(ev(0,0,0,0,0,0,0,1,32'h900,0));
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rob_head = 5'd0; rob_tail = 5'd10;
        issue(1, 1, 9, 32'h900);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            idle_in();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_errors++;
                $display("FAIL empty_walk cycle %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    // Older mispredict restarts recovery; a later younger one is ignored.
    task automatic test_older_mispredict();
        obs_t exp_q[$];
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(1,10,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,15,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(1,6,0,0,0,0,0,0,0,1));
        for (int k = 15; k >= 7; k--) exp_q.push_back(ev(0,0,1,k,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,0,0,1,0,6,0,0,1));
        exp_q.push_back(ev(0,0,0,0,0,0,0,1,32'h600,0));
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rob_head = 5'd0; rob_tail = 5'd16;
        issue(1, 0, 10, 32'hA00);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            idle_in();
            if (i == 2) issue(1, 0, 6, 32'h600);
            if (i == 6) issue(1, 0, 12, 32'hC00);
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_errors++;
                $display("FAIL older_mp cycle %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    // Older hit frees during walk, younger hit ignored, hit on restore cycle held.
    task automatic test_hit_during_recovery();
        obs_t exp_q[$];
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(1,4,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,7,0,1,2,0,0,1));
        exp_q.push_back(ev(0,0,1,6,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,5,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,0,0,1,0,4,0,0,1));
        exp_q.push_back(ev(0,0,0,0,0,1,1,1,32'h300,0));
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rob_head = 5'd0; rob_tail = 5'd8;
        issue(1, 0, 4, 32'h300);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            idle_in();
            if (i == 1) issue(0, 1, 2, 32'h0);
            if (i == 2) issue(0, 1, 6, 32'h0);
            if (i == 4) issue(0, 1, 1, 32'h0);
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_errors++;
                $display("FAIL hit_recov cycle %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        obs_t exp_q[$];
        exp_q.push_back(ev(0,0,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(1,4,0,0,0,0,0,0,0,1));
        exp_q.push_back(ev(0,0,1,7,0,0,0,0,0,1));
        @(negedge clk);
        rob_head = 5'd0; rob_tail = 5'd8;
        issue(1, 0, 4, 32'h400);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            idle_in();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_errors++;
                $display("FAIL reset_mid pre cycle %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({flush_valid, walk_valid, walk_idx, ckpt_restore, ckpt_free, redirect_valid, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid async_clear: got %h expected 0", obs());
        end
        @(negedge clk);
        reset = 1'b0;
        issue(0, 1, 3, 32'h0);
        @(negedge clk);
        idle_in();
        n_checks++;
        if (obs() !== ev(0,0,0,0,0,1,3,0,0,0)) begin
            n_errors++;
            $display("FAIL reset_mid hit_after: got %h expected %h", obs(), ev(0,0,0,0,0,1,3,0,0,0));
        end
        @(negedge clk);
        n_checks++;
        if (obs() !== '0) begin
            n_errors++;
            $display("FAIL reset_mid idle_after: got %h expected 0", obs());
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_bne();
        test_wrap();
        test_empty_walk();
        test_older_mispredict();
        test_hit_during_recovery();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
